// File: rtl/ifid_pkg.sv
// ifid_pkg: shared widths, NOP word and state encoding for the IF/ID skid register
package ifid_pkg;
    localparam int DEF_INSWIDTH = 32;
    localparam int DEF_AWIDTH = 32;
    localparam logic [31:0] DEF_NOPINS = 32'h00000000;
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE = 2'b10;
    localparam logic [1:0] ST_FULL = 2'b11;
    function automatic logic [1:0] occ_of(input logic [1:0] s);
        return {1'b0, s[1]} + {1'b0, s[0]};
    endfunction
endpackage

// File: rtl/ifid_skidreg_pipeslot.sv
// pipeslot: data+valid register with load and clear; clear overwrites only the CLRMASK bits
import ifid_pkg::*;
module pipeslot #(
    parameter int W = DEF_INSWIDTH + DEF_AWIDTH,
    parameter logic [W-1:0] RSTVAL = '0,
    parameter logic [W-1:0] CLRMASK = '0,
    parameter logic [W-1:0] CLRVAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RSTVAL;
            valid <= 1'b0;
        end else if (clear) begin
            q <= (q & ~CLRMASK) | (CLRVAL & CLRMASK);
            valid <= 1'b0;
        end else if (load) begin
            q <= d;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/ifid_skidreg.sv
// ifid_skidreg: elastic IF/ID stage with main+skid slots, flush bubble insertion and occupancy
import ifid_pkg::*;
module ifid_skidreg #(
    parameter int INSWIDTH = DEF_INSWIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter logic [INSWIDTH-1:0] NOPINS = INSWIDTH'(DEF_NOPINS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INSWIDTH-1:0] insin,
    input  logic [AWIDTH-1:0]   pcnextin,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [INSWIDTH-1:0] insout,
    output logic [AWIDTH-1:0]   pcnextout,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                flush,
    output logic [1:0]          occupancy
);
    localparam int W = INSWIDTH + AWIDTH;
    logic main_v, skid_v, accept, consume, illegal;
    logic main_load, main_clr, skid_load, skid_clr;
    logic [1:0] st;
    logic [W-1:0] main_q, skid_q, in_d, main_d;
    assign in_d = {insin, pcnextin};
    assign st = {main_v, skid_v};
    assign in_ready = !skid_v;
    assign out_valid = main_v;
    assign accept = in_valid && in_ready;
    assign consume = out_valid && out_ready;
    assign illegal = !main_v && skid_v;
    assign occupancy = occ_of(st);
    assign {insout, pcnextout} = main_q;
    assign main_d = st == ST_FULL ? skid_q : in_d;
    // flush and the unreachable (0,1) state both collapse to EMPTY via clear
    always_comb begin
        main_load = !flush && ((st == ST_EMPTY && accept) || (st == ST_ONE && accept && consume) || (st == ST_FULL && consume));
        main_clr = flush || illegal || (st == ST_ONE && consume && !accept);
        skid_load = !flush && st == ST_ONE && accept && !consume;
        skid_clr = flush || illegal || (st == ST_FULL && consume);
    end
    pipeslot #(
        .W(W),
        .RSTVAL({NOPINS, {AWIDTH{1'b0}}}),
        .CLRMASK({{INSWIDTH{1'b1}}, {AWIDTH{1'b0}}}),
        .CLRVAL({NOPINS, {AWIDTH{1'b0}}})
    ) u_main (
        .clk(clk),
        .rst_n(rst_n),
        .load(main_load),
        .clear(main_clr),
        .d(main_d),
        .q(main_q),
        .valid(main_v)
    );
    pipeslot #(
        .W(W),
        .RSTVAL('0),
        .CLRMASK('0),
        .CLRVAL('0)
    ) u_skid (
        .clk(clk),
        .rst_n(rst_n),
        .load(skid_load),
        .clear(skid_clr),
        .d(in_d),
        .q(skid_q),
        .valid(skid_v)
    );
endmodule

// File: tb/tb_ifid_skidreg.sv
// tb_ifid_skidreg: directed stimulus with a queue model checked every cycle plus literal expectations
module tb_ifid_skidreg;
    import ifid_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] insin = '0, pcnextin = '0;
    logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic in_ready, out_valid;
    logic [31:0] insout, pcnextout;
    logic [1:0] occupancy;
    int checks = 0;
    int failures = 0;

    ifid_skidreg dut (
        .clk(clk),
        .rst_n(rst_n),
        .insin(insin),
        .pcnextin(pcnextin),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .insout(insout),
        .pcnextout(pcnextout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .flush(flush),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;
    ent_t mq[$];
    logic [31:0] m_pc = '0;

    // Model: a FIFO of at most two entries; the shown PC sticks once the FIFO empties
    always @(posedge clk or negedge rst_n) begin : model
        bit acc, con;
        if (!rst_n) begin
            mq.delete();
            m_pc = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            acc = in_valid && mq.size() < 2;
            con = mq.size() > 0 && out_ready;
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back('{insin, pcnextin});
            if (mq.size() > 0) m_pc = mq[0].pc;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e_ins, e_pc;
        e_ins = DEF_NOPINS;
        e_pc = m_pc;
        if (mq.size() > 0) begin
            e_ins = mq[0].ins;
            e_pc = mq[0].pc;
        end
        check("m_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
        check("m_in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
        check("m_occupancy", {30'b0, occupancy}, 32'(mq.size()));
        check("m_insout", insout, e_ins);
        check("m_pcnextout", pcnextout, e_pc);
    end

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        insin = ins;
        pcnextin = pc;
    endtask

    task automatic edge_step();
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy, input logic [1:0] occ);
        check({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
        check({tag, "_ins"}, insout, ins);
        check({tag, "_pc"}, pcnextout, pc);
        check({tag, "_ready"}, {31'b0, in_ready}, {31'b0, rdy});
        check({tag, "_occ"}, {30'b0, occupancy}, {30'b0, occ});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        expect_out("reset", 1'b0, 32'h0, 32'h0, 1'b1, 2'd0);
        rst_n = 1'b1;
        // stream with decode always ready
        out_ready = 1'b1;
        offer(1'b1, 32'h20080001, 32'h00000004);
        edge_step();
        expect_out("s1a", 1'b1, 32'h20080001, 32'h4, 1'b1, 2'd1);
        offer(1'b1, 32'h20090002, 32'h00000008);
        edge_step();
        expect_out("s1b", 1'b1, 32'h20090002, 32'h8, 1'b1, 2'd1);
        offer(1'b1, 32'h200A0003, 32'h0000000C);
        edge_step();
        expect_out("s1c", 1'b1, 32'h200A0003, 32'hC, 1'b1, 2'd1);
        offer(1'b0, 32'hDEADBEEF, 32'hFFFFFFF0);
        edge_step();
        expect_out("bubble", 1'b0, 32'h0, 32'hC, 1'b1, 2'd0);
        // stall fill
        out_ready = 1'b0;
        offer(1'b1, 32'h11111111, 32'h00000010);
        edge_step();
        expect_out("s2a", 1'b1, 32'h11111111, 32'h10, 1'b1, 2'd1);
        offer(1'b1, 32'h22222222, 32'h00000014);
        edge_step();
        expect_out("s2b", 1'b1, 32'h11111111, 32'h10, 1'b0, 2'd2);
        offer(1'b1, 32'h33333333, 32'h00000018);
        edge_step();
        expect_out("s2c", 1'b1, 32'h11111111, 32'h10, 1'b0, 2'd2);
        // drain
        out_ready = 1'b1;
        edge_step();
        expect_out("s3a", 1'b1, 32'h22222222, 32'h14, 1'b1, 2'd1);
        edge_step();
        expect_out("s3b", 1'b1, 32'h33333333, 32'h18, 1'b1, 2'd1);
        offer(1'b0, 32'h0, 32'h0);
        edge_step();
        expect_out("s3c", 1'b0, 32'h0, 32'h18, 1'b1, 2'd0);
        // flush while full with an entry offered
        out_ready = 1'b0;
        offer(1'b1, 32'hAAAA0001, 32'h00000020);
        edge_step();
        offer(1'b1, 32'hAAAA0002, 32'h00000024);
        edge_step();
        expect_out("s4full", 1'b1, 32'hAAAA0001, 32'h20, 1'b0, 2'd2);
        flush = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 32'hBBBB0003, 32'h00000028);
        edge_step();
        expect_out("s4flush", 1'b0, 32'h0, 32'h20, 1'b1, 2'd0);
        offer(1'b1, 32'hBBBB0004, 32'h0000002C);
        edge_step();
        expect_out("s4flushempty", 1'b0, 32'h0, 32'h20, 1'b1, 2'd0);
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        edge_step();
        expect_out("s4after", 1'b0, 32'h0, 32'h20, 1'b1, 2'd0);
        // async reset while full
        out_ready = 1'b0;
        offer(1'b1, 32'hCCCC0001, 32'h00000030);
        edge_step();
        offer(1'b1, 32'hCCCC0002, 32'h00000034);
        edge_step();
        offer(1'b0, 32'h0, 32'h0);
        expect_out("s5full", 1'b1, 32'hCCCC0001, 32'h30, 1'b0, 2'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 expect_out("s5async", 1'b0, 32'h0, 32'h0, 1'b1, 2'd0);
        edge_step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 32'hDDDD0001, 32'h00000040);
        edge_step();
        expect_out("s5post", 1'b1, 32'hDDDD0001, 32'h40, 1'b1, 2'd1);
        offer(1'b0, 32'h0, 32'h0);
        repeat (2) edge_step();
        expect_out("s5end", 1'b0, 32'h0, 32'h40, 1'b1, 2'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
